tmds_rx_align_decode: RTL and testbench

// - Receive-side counterpart of the TMDS serializer: takes 10-bit words from a per-lane ISERDES
//   (already in pixel_clk domain) and finds word alignment by pulsing ISERDES bitslip.
// - Decodes each aligned word into 8-bit video data or a 2-bit control value plus data-enable.
// - One instance per TMDS lane (blue/green/red), ahead of the sync/timing recovery logic.

---
 rtl/tmds_rx_align_decode_pkg.sv | 25 ++
 rtl/tmds_rx_align_decode_word.sv | 33 +++
 rtl/tmds_rx_align_decode.sv | 162 ++++++++++++++++
 tb/tb_tmds_rx_align_decode.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_rx_align_decode_pkg.sv
// Shared definitions for the TMDS receive lane: control-token codes,
// aligner FSM states and the decoded-word record.
package tmds_rx_align_decode_pkg;

    // The four TMDS control tokens, bit 0 = first serial bit.
    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // de = 0 means the word was a control token (ctrl valid, data 0).
    typedef struct packed {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } dec_t;

endpackage

// File: rtl/tmds_rx_align_decode_word.sv
// Purely combinational TMDS 10b word decoder.
// Ports:
//   word  in   10  raw TMDS word, bit 0 = first serial bit
//   dec   out  dec_t {de, ctrl, data}; token -> de=0/ctrl, otherwise de=1/data
module tmds_decode_word
    import tmds_rx_align_decode_pkg::*;
(
    input  logic [9:0] word,
    output dec_t       dec
);

    logic [7:0] d;

    always_comb begin
        // Undo the optional inversion first, then undo the XOR/XNOR chain.
        d   = word[9] ? ~word[7:0] : word[7:0];
        dec = '0;
        case (word)
            TOK_C00: dec.ctrl = 2'b00;
            TOK_C01: dec.ctrl = 2'b01;
            TOK_C10: dec.ctrl = 2'b10;
            TOK_C11: dec.ctrl = 2'b11;
            default: begin
                dec.de      = 1'b1;
                dec.data[0] = d[0];
                for (int i = 1; i < 8; i++) begin
                    dec.data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_rx_align_decode.sv
// TMDS receive lane: word alignment via ISERDES bitslip plus 10b decode.
// A long run of control tokens marks correct alignment; without one the
// aligner slips the ISERDES by one bit every search timeout. While locked,
// blanking intervals (short token runs) keep a watchdog from expiring.
// Ports:
//   pixel_clk  in   1   pixel clock, rising edge
//   rst_n      in   1   async active-low reset (release expected synchronous)
//   tmds_word  in   10  word from ISERDES, bit 0 = first serial bit
//   bitslip    out  1   one-cycle pulse to ISERDES BITSLIP
//   aligned    out  1   high while locked
//   de         out  1   1 = data word, 0 = token or not aligned
//   ctrl       out  2   control value for token words, else 0
//   data       out  8   decoded byte when de = 1, else 0
// Latency tmds_word -> de/ctrl/data is 2 cycles.
module tmds_rx_align_decode
    import tmds_rx_align_decode_pkg::*;
#(
    parameter int LOCK_RUN    = 64,
    parameter int SEARCH_TMO  = 2048,
    parameter int SLIP_SETTLE = 3,
    parameter int BLANK_RUN   = 8,
    parameter int LOCK_TMO    = 4096
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic [9:0] tmds_word,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    localparam int RUN_MAX = (LOCK_RUN > BLANK_RUN) ? LOCK_RUN : BLANK_RUN;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int TMO_W   = $clog2(SEARCH_TMO);
    localparam int SET_W   = (SLIP_SETTLE > 1) ? $clog2(SLIP_SETTLE) : 1;
    localparam int WD_W    = $clog2(LOCK_TMO);

    logic [9:0]       word_s1;
    dec_t             dec_s1;
    logic             tok_s1;
    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [SET_W-1:0] set_cnt, set_nxt;
    logic [WD_W-1:0]  wd_cnt, wd_nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;
    logic             run_clr;
    logic             aligned_nxt, bitslip_nxt;

    // ---------------- stage 1: input register + token run length ----------
    tmds_decode_word u_dec (
        .word (word_s1),
        .dec  (dec_s1)
    );

    assign tok_s1 = ~dec_s1.de;

    always_comb begin
        run_nxt = '0;
        if (!run_clr && tok_s1) begin
            run_nxt = (run_cnt == RUN_W'(RUN_MAX)) ? run_cnt : run_cnt + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_s1 <= '0;
            run_cnt <= '0;
        end else begin
            word_s1 <= tmds_word;
            run_cnt <= run_nxt;
        end
    end

    // ---------------- aligner FSM: state register --------------------------
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SEARCH;
            tmo_cnt <= '0;
            set_cnt <= '0;
            wd_cnt  <= '0;
            aligned <= 1'b0;
            bitslip <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
            set_cnt <= set_nxt;
            wd_cnt  <= wd_nxt;
            aligned <= aligned_nxt;
            bitslip <= bitslip_nxt;
        end
    end

    // ---------------- aligner FSM: next state ------------------------------
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        set_nxt   = set_cnt;
        wd_nxt    = wd_cnt;
        run_clr   = 1'b0;
        case (state)
            ST_SEARCH: begin
                // A completed token run wins over a coincident timeout.
                if (run_cnt >= RUN_W'(LOCK_RUN)) begin
                    state_nxt = ST_LOCKED;
                    wd_nxt    = '0;
                end else if (tmo_cnt == TMO_W'(SEARCH_TMO - 1)) begin
                    state_nxt = ST_SLIP;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            ST_SLIP: begin
                state_nxt = ST_SETTLE;
                set_nxt   = '0;
            end
            ST_SETTLE: begin
                // Words around a slip are garbage; keep them out of the run.
                run_clr = 1'b1;
                if (set_cnt == SET_W'(SLIP_SETTLE - 1)) begin
                    state_nxt = ST_SEARCH;
                    tmo_nxt   = '0;
                end else begin
                    set_nxt = set_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (run_cnt >= RUN_W'(BLANK_RUN)) begin
                    wd_nxt = '0;
                end else if (wd_cnt == WD_W'(LOCK_TMO - 1)) begin
                    state_nxt = ST_SEARCH;
                    tmo_nxt   = '0;
                    run_clr   = 1'b1;
                end else begin
                    wd_nxt = wd_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    // ---------------- aligner FSM: registered outputs ----------------------
    always_comb begin
        aligned_nxt = (state_nxt == ST_LOCKED);
        bitslip_nxt = (state_nxt == ST_SLIP);
    end

    // ---------------- stage 2: decode result, gated by lock ----------------
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            de   <= 1'b0;
            ctrl <= 2'b00;
            data <= 8'h00;
        end else begin
            de   <= aligned & dec_s1.de;
            ctrl <= aligned ? dec_s1.ctrl : 2'b00;
            data <= aligned ? dec_s1.data : 8'h00;
        end
    end

endmodule

// File: tb/tb_tmds_rx_align_decode.sv
// Randomized scoreboard bench for tmds_rx_align_decode. A behavioural lane
// model predicts every cycle's outputs; the stimulus process queues the
// prediction and a monitor compares it against the DUT one cycle at a time.
module tb_tmds_rx_align_decode;

    localparam int LOCK_RUN    = 64;
    localparam int SEARCH_TMO  = 2048;
    localparam int SLIP_SETTLE = 3;
    localparam int BLANK_RUN   = 8;
    localparam int LOCK_TMO    = 4096;
    localparam int RUN_MAX     = 64;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    localparam int M_SEARCH = 0, M_SLIP = 1, M_SETTLE = 2, M_LOCKED = 3;

    typedef struct packed {
        logic       aligned;
        logic       bitslip;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } obs_t;

    logic       pixel_clk = 1'b0;
    logic       rst_n;
    logic [9:0] tmds_word;
    logic       bitslip, aligned, de;
    logic [1:0] ctrl;
    logic [7:0] data;

    always #5 pixel_clk = ~pixel_clk;

    tmds_rx_align_decode dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .tmds_word (tmds_word),
        .bitslip   (bitslip),
        .aligned   (aligned),
        .de        (de),
        .ctrl      (ctrl),
        .data      (data)
    );

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // lane model
    int         m_mode;
    logic [9:0] m_w1;
    bit         m_al;
    int         m_run, search_left, settle_left, quiet_left;
    int         off;   // ISERDES word offset in bits, 0 = aligned

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
            if (errors >= 25) finish_run();
        end
    endtask

    function automatic int tok_val(input logic [9:0] w);
        case (w)
            T00: return 0;
            T01: return 1;
            T10: return 2;
            T11: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [9:0] tok_code(input int v);
        case (v)
            0: return T00;
            1: return T01;
            2: return T10;
            default: return T11;
        endcase
    endfunction

    function automatic logic [7:0] ref_data(input logic [9:0] w);
        logic [7:0] d, q;
        d = w[9] ? ~w[7:0] : w[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = d[i] ^ d[i-1] ^ ~w[8];
        return q;
    endfunction

    // word seen by the receiver when the serial stream is k bits off
    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] dbl;
        dbl = {w, w};
        return dbl[k +: 10];
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (tok_val(w) >= 0);
        return w;
    endfunction

    task automatic model_reset();
        m_mode      = M_SEARCH;
        m_w1        = '0;
        m_al        = 1'b0;
        m_run       = 0;
        search_left = SEARCH_TMO;
        settle_left = 0;
        quiet_left  = LOCK_TMO;
    endtask

    // Advance the model by one clock edge at which word x is captured;
    // e receives the outputs visible right after that edge.
    task automatic model_step(input logic [9:0] x, output obs_t e);
        int t;
        bit clear_run;
        t         = tok_val(m_w1);
        clear_run = (m_mode == M_SETTLE);
        e         = '0;
        if (m_al) begin
            if (t >= 0) e.ctrl = 2'(t);
            else begin
                e.de   = 1'b1;
                e.data = ref_data(m_w1);
            end
        end
        case (m_mode)
            M_SEARCH: begin
                if (m_run >= LOCK_RUN) begin
                    m_mode     = M_LOCKED;
                    quiet_left = LOCK_TMO;
                end else begin
                    search_left--;
                    if (search_left == 0) m_mode = M_SLIP;
                end
            end
            M_SLIP: begin
                m_mode      = M_SETTLE;
                settle_left = SLIP_SETTLE;
            end
            M_SETTLE: begin
                settle_left--;
                if (settle_left == 0) begin
                    m_mode      = M_SEARCH;
                    search_left = SEARCH_TMO;
                end
            end
            default: begin
                if (m_run >= BLANK_RUN) quiet_left = LOCK_TMO;
                else begin
                    quiet_left--;
                    if (quiet_left == 0) begin
                        m_mode      = M_SEARCH;
                        search_left = SEARCH_TMO;
                        clear_run   = 1'b1;
                    end
                end
            end
        endcase
        if (clear_run || t < 0) m_run = 0;
        else m_run = (m_run + 1 > RUN_MAX) ? RUN_MAX : m_run + 1;
        m_al      = (m_mode == M_LOCKED);
        e.aligned = m_al;
        e.bitslip = (m_mode == M_SLIP);
        m_w1      = x;
    endtask

    // Drive one word, predict, wait for the edge, queue the prediction.
    task automatic cycle(input logic [9:0] x);
        obs_t e;
        tmds_word = x;
        if (!rst_n) begin
            model_reset();
            e = '0;
        end else begin
            model_step(x, e);
        end
        @(posedge pixel_clk);
        sb.push_back(e);
        if (e.bitslip) off = (off + 9) % 10;
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_aligned", int'(aligned), 0);
        chk("async_rst_bitslip", int'(bitslip), 0);
        chk("async_rst_de", int'(de), 0);
        model_reset();
        repeat (2) cycle(tok_code(int'($urandom_range(0, 3))));
        rst_n = 1'b1;
    endtask

    // monitor
    initial begin
        obs_t got, exp;
        forever begin
            @(posedge pixel_clk);
            #2;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                got = {aligned, bitslip, de, ctrl, data};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL out @%0t: got al=%0b bs=%0b de=%0b ctrl=%0d data=%02h, want al=%0b bs=%0b de=%0b ctrl=%0d data=%02h",
                             $time, got.aligned, got.bitslip, got.de, got.ctrl, got.data,
                             exp.aligned, exp.bitslip, exp.de, exp.ctrl, exp.data);
                    if (errors >= 25) finish_run();
                end
            end
        end
    end

    // stimulus
    initial begin
        rst_n     = 1'b0;
        tmds_word = '0;
        off       = 0;
        model_reset();

        // reset held with tokens on the input
        repeat (6) cycle(tok_code(int'($urandom_range(0, 3))));
        chk("reset_aligned", int'(aligned), 0);
        chk("reset_bitslip", int'(bitslip), 0);
        chk("reset_data", int'(data), 0);
        rst_n = 1'b1;

        // aligned token stream
        repeat (80) cycle(T00);
        chk("lock_aligned", int'(aligned), 1);

        // directed data words, then a random data/token mix
        cycle(10'b0100000000);
        cycle(10'b1011111111);
        cycle(10'b0111111111);
        repeat (60) begin
            if ($urandom_range(0, 4) == 0) cycle(tok_code(int'($urandom_range(0, 3))));
            else cycle(rand_data());
        end
        repeat (10) cycle(tok_code(int'($urandom_range(0, 3))));

        // lock loss: no blanking for longer than the watchdog
        repeat (LOCK_TMO + 100) cycle(rand_data());
        chk("lockloss_aligned", int'(aligned), 0);

        // misaligned by 3 bits from a fresh reset
        async_reset();
        off = 3;
        repeat (3 * (SEARCH_TMO + SLIP_SETTLE + 1) + 200) cycle(rot(T00, off));
        chk("misalign_offset", off, 0);
        chk("misalign_aligned", int'(aligned), 1);

        // blanking keepalive, with a reset in the middle of line 10
        for (int line = 0; line < 20; line++) begin
            for (int k = 0; k < 2000; k++) begin
                if (line == 10 && k == 1000) begin
                    async_reset();
                    repeat (70) cycle(tok_code(int'($urandom_range(0, 3))));
                end
                cycle(rand_data());
            end
            repeat (BLANK_RUN) cycle(tok_code(int'($urandom_range(0, 3))));
            chk("keepalive_aligned", int'(aligned), 1);
        end

        @(posedge pixel_clk);
        #3;
        chk("sb_drained", sb.size(), 0);
        finish_run();
    end

endmodule
